vxe_regio_arb: RTL and testbench
================================

VXE_REGIO_ARB -- requirements
Module: vxe_regio_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255 (8-bit compare), max cycles waited for a regio response before error.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port i_mN_wreq (N=0,1), input, 1, write request level, held until o_mN_wdone.
REQ-005 SHALL have port i_mN_wreg_idx / i_mN_wdata, input, 10 / 32, write index/data, stable while i_mN_wreq.
REQ-006 SHALL have port i_mN_rreq, input, 1, read request level, held until o_mN_rdone.
REQ-007 SHALL have port i_mN_rreg_idx, input, 10, read index, stable while i_mN_rreq.
REQ-008 SHALL have port o_mN_wdone / o_mN_rdone, output, 1, one-cycle completion pulse to master N.
REQ-009 SHALL have port o_werr / o_rerr / o_rdata, output, 1 / 1 / 32, shared status and read data, valid only with a done pulse.
REQ-010 SHALL have ports o_wreg_idx 10, o_wdata 32, o_wenable 1 (outputs); i_waccept 1, i_werror 1 (inputs): regio write port.
REQ-011 SHALL have ports o_rreg_idx 10, o_renable 1 (outputs); i_rdata 32, i_raccept 1, i_rerror 1 (inputs): regio read port.

Function
REQ-012 SHALL run write and read channels as independent identical FSMs; both may be busy in the same cycle.
REQ-013 Each channel SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-014 IDLE: if any req asserted, SHALL grant one master, register its idx (and wdata), and go to ISSUE next cycle; else stay.
REQ-015 Arbitration SHALL be round-robin per channel: on simultaneous requests, grant the master not granted last; last-grant resets to m1, so m0 wins the first tie.
REQ-016 ISSUE SHALL drive enable=1 for exactly one cycle with registered idx/data, clear the timeout counter, then go to WAIT.
REQ-017 Enable SHALL be 0 in all states other than ISSUE; idx/data outputs SHALL hold their last granted value.
REQ-018 A response (accept or error) SHALL be recognised in ISSUE or WAIT and move the FSM to RESP; accept and error together SHALL be treated as error.
REQ-019 On read response, SHALL capture i_rdata into o_rdata in the same edge; o_rdata holds until the next read response.
REQ-020 WAIT SHALL increment the 8-bit counter each cycle; on counter == TIMEOUT with no response, SHALL go to RESP flagged error.
REQ-021 RESP SHALL pulse done of the granted master for one cycle with err = captured error flag, then return to IDLE.
REQ-022 Err outputs SHALL be 0 whenever the corresponding done pulses are low.
REQ-023 Responses arriving in IDLE or RESP SHALL be ignored.
REQ-024 Request-to-done latency SHALL be 3 cycles + regio response delay (response in ISSUE gives minimum 3).
REQ-025 Masters SHALL drop req in the cycle following done; a req still high in IDLE SHALL be treated as a new request.

Reset
REQ-026 rst high SHALL asynchronously force both FSMs to IDLE, counters to 0, last-grant to m1, and all outputs (enables, dones, errs, idx, wdata, rdata) to 0.
REQ-027 Reset mid-transaction SHALL abandon it with no done pulse; a later response from regio SHALL be ignored.

Verification
REQ-028 m0 write idx 0x004 data 0x00000001, i_waccept 2 cycles after o_wenable -> one-cycle o_wenable with those values, o_m0_wdone 1 cycle after accept, o_werr=0.
REQ-029 m0 and m1 wreq together from reset, twice -> order m0, m1, m0, m1; no overlap of o_wenable.
REQ-030 m1 read idx 0x010, i_rdata=0xbeefdeaf with i_raccept -> o_m1_rdone pulse, o_rdata=0xbeefdeaf, o_rerr=0; i_rerror instead -> o_rerr=1.
REQ-031 TIMEOUT=8, no response -> o_m0_rdone with o_rerr=1 exactly 12 cycles after req; late i_raccept produces no pulse.
REQ-032 m0 write and m1 read concurrent -> both enables may assert same cycle, both dones delivered with correct err.
REQ-033 rst pulsed during WAIT -> all outputs 0 immediately, no done, next request serviced normally.

Source files
------------

// File: rtl/vxe_regio_arb.sv
// vxe_regio_arb: two-master arbiter in front of a single regio register port.
// Write and read traffic run on independent channels (c=0 write, c=1 read).
// Each channel is an IDLE/ISSUE/WAIT/RESP FSM with round-robin grant and a
// response timeout. Done/err are decoded from the RESP state, so they are
// exactly one cycle wide and drop to 0 as soon as reset asserts.
module vxe_regio_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_m0_wreq,
    input  logic [9:0]  i_m0_wreg_idx,
    input  logic [31:0] i_m0_wdata,
    input  logic        i_m0_rreq,
    input  logic [9:0]  i_m0_rreg_idx,
    input  logic        i_m1_wreq,
    input  logic [9:0]  i_m1_wreg_idx,
    input  logic [31:0] i_m1_wdata,
    input  logic        i_m1_rreq,
    input  logic [9:0]  i_m1_rreg_idx,
    output logic        o_m0_wdone,
    output logic        o_m0_rdone,
    output logic        o_m1_wdone,
    output logic        o_m1_rdone,
    output logic        o_werr,
    output logic        o_rerr,
    output logic [31:0] o_rdata,
    output logic [9:0]  o_wreg_idx,
    output logic [31:0] o_wdata,
    output logic        o_wenable,
    input  logic        i_waccept,
    input  logic        i_werror,
    output logic [9:0]  o_rreg_idx,
    output logic        o_renable,
    input  logic [31:0] i_rdata,
    input  logic        i_raccept,
    input  logic        i_rerror
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    // Per-channel views of the master/regio signals: [channel][master].
    logic [1:0][1:0]      req;
    logic [1:0][1:0][9:0] idx_in;
    logic [1:0]           acc;
    logic [1:0]           rerr_in;
    logic [1:0]           en;
    logic [1:0][9:0]      idx_o;
    logic [1:0][1:0]      done;
    logic [1:0]           errs;

    assign req[0]     = {i_m1_wreq, i_m0_wreq};
    assign req[1]     = {i_m1_rreq, i_m0_rreq};
    assign idx_in[0]  = {i_m1_wreg_idx, i_m0_wreg_idx};
    assign idx_in[1]  = {i_m1_rreg_idx, i_m0_rreg_idx};
    assign acc        = {i_raccept, i_waccept};
    assign rerr_in    = {i_rerror, i_werror};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        state_t     st, st_nxt;
        logic [7:0] cnt_q;
        logic       gnt_q, last_q, err_q, sel, hit, tmo;
        logic [9:0] idx_q;

        // Responses count only while a request is outstanding.
        assign hit = (st == S_ISSUE || st == S_WAIT) && (acc[c] || rerr_in[c]);
        assign tmo = (st == S_WAIT) && (cnt_q == TO_CNT);
        // On a tie, favour the master that was not granted last.
        assign sel = (req[c] == 2'b11) ? ~last_q : req[c][1];

        // Next-state decode.
        always_comb begin
            st_nxt = st;
            case (st)
                S_IDLE:  if (|req[c]) st_nxt = S_ISSUE;
                S_ISSUE: st_nxt = hit ? S_RESP : S_WAIT;
                S_WAIT:  if (hit || tmo) st_nxt = S_RESP;
                S_RESP:  st_nxt = S_IDLE;
                default: st_nxt = S_IDLE;
            endcase
        end

        // State register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) st <= S_IDLE;
            else     st <= st_nxt;
        end

        // Grant bookkeeping, timeout counter and captured error flag.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                gnt_q  <= 1'b0;
                last_q <= 1'b1;
                idx_q  <= '0;
                cnt_q  <= '0;
                err_q  <= 1'b0;
            end else begin
                if (st == S_IDLE && |req[c]) begin
                    gnt_q  <= sel;
                    last_q <= sel;
                    idx_q  <= sel ? idx_in[c][1] : idx_in[c][0];
                end
                if (st == S_ISSUE)                cnt_q <= '0;
                else if (st == S_WAIT && !tmo)    cnt_q <= cnt_q + 8'd1;
                // error wins when accept and error arrive together
                if (hit)      err_q <= rerr_in[c];
                else if (tmo) err_q <= 1'b1;
            end
        end

        assign en[c]    = (st == S_ISSUE);
        assign idx_o[c] = idx_q;
        assign done[c]  = {(st == S_RESP) && gnt_q, (st == S_RESP) && !gnt_q};
        assign errs[c]  = (st == S_RESP) && err_q;

        if (c == 0) begin : g_wdata
            // Write data follows the granted master, held between grants.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                         o_wdata <= '0;
                else if (st == S_IDLE && |req[c]) o_wdata <= sel ? i_m1_wdata : i_m0_wdata;
            end
        end else begin : g_rdata
            // Read data is taken on the same edge the response is recognised.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)      o_rdata <= '0;
                else if (hit) o_rdata <= i_rdata;
            end
        end
    end

    assign o_wenable  = en[0];
    assign o_renable  = en[1];
    assign o_wreg_idx = idx_o[0];
    assign o_rreg_idx = idx_o[1];
    assign o_m0_wdone = done[0][0];
    assign o_m1_wdone = done[0][1];
    assign o_m0_rdone = done[1][0];
    assign o_m1_rdone = done[1][1];
    assign o_werr     = errs[0];
    assign o_rerr     = errs[1];

endmodule

// File: tb/tb_vxe_regio_arb.sv
// Directed bench for vxe_regio_arb (TIMEOUT=8). Inputs are driven and outputs
// sampled 1ns after each rising edge. "Cycle 1" below is the cycle after the
// request is raised (the ISSUE cycle).
module tb_vxe_regio_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_m0_wreq, i_m0_rreq, i_m1_wreq, i_m1_rreq;
    logic [9:0]  i_m0_wreg_idx, i_m0_rreg_idx, i_m1_wreg_idx, i_m1_rreg_idx;
    logic [31:0] i_m0_wdata, i_m1_wdata;
    logic        o_m0_wdone, o_m0_rdone, o_m1_wdone, o_m1_rdone;
    logic        o_werr, o_rerr;
    logic [31:0] o_rdata;
    logic [9:0]  o_wreg_idx, o_rreg_idx;
    logic [31:0] o_wdata;
    logic        o_wenable, o_renable;
    logic        i_waccept, i_werror, i_raccept, i_rerror;
    logic [31:0] i_rdata;

    int n_chk = 0;
    int n_err = 0;
    logic [9:0] order[$];

    always #5 clk = ~clk;

    vxe_regio_arb #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_m0_wreq(i_m0_wreq), .i_m0_wreg_idx(i_m0_wreg_idx), .i_m0_wdata(i_m0_wdata),
        .i_m0_rreq(i_m0_rreq), .i_m0_rreg_idx(i_m0_rreg_idx),
        .i_m1_wreq(i_m1_wreq), .i_m1_wreg_idx(i_m1_wreg_idx), .i_m1_wdata(i_m1_wdata),
        .i_m1_rreq(i_m1_rreq), .i_m1_rreg_idx(i_m1_rreg_idx),
        .o_m0_wdone(o_m0_wdone), .o_m0_rdone(o_m0_rdone),
        .o_m1_wdone(o_m1_wdone), .o_m1_rdone(o_m1_rdone),
        .o_werr(o_werr), .o_rerr(o_rerr), .o_rdata(o_rdata),
        .o_wreg_idx(o_wreg_idx), .o_wdata(o_wdata), .o_wenable(o_wenable),
        .i_waccept(i_waccept), .i_werror(i_werror),
        .o_rreg_idx(o_rreg_idx), .o_renable(o_renable),
        .i_rdata(i_rdata), .i_raccept(i_raccept), .i_rerror(i_rerror)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_en"},   {30'd0, o_renable, o_wenable}, 0);
        chk({tag, "_done"}, {28'd0, o_m1_rdone, o_m0_rdone, o_m1_wdone, o_m0_wdone}, 0);
        chk({tag, "_err"},  {30'd0, o_rerr, o_werr}, 0);
    endtask

    // mode: 0 accept, 1 error, 2 accept+error; response raised in cycle 1+dly
    task automatic do_wr(input bit m, input logic [9:0] idx, input logic [31:0] d,
                         input int dly, input int mode);
        if (m) begin i_m1_wreq = 1; i_m1_wreg_idx = idx; i_m1_wdata = d; end
        else   begin i_m0_wreq = 1; i_m0_wreg_idx = idx; i_m0_wdata = d; end
        tick;
        chk("wr_en", o_wenable, 1);
        chk("wr_idx", o_wreg_idx, idx);
        chk("wr_data", o_wdata, d);
        for (int c = 0; c < dly; c++) begin
            chk("wr_early_done", {o_m1_wdone, o_m0_wdone}, 0);
            tick;
            if (c == 0) chk("wr_en_one_cycle", o_wenable, 0);
        end
        i_waccept = (mode != 1);
        i_werror  = (mode != 0);
        tick;
        i_waccept = 0; i_werror = 0;
        chk("wr_done_m0", o_m0_wdone, !m);
        chk("wr_done_m1", o_m1_wdone, m);
        chk("wr_err", o_werr, (mode != 0));
        tick;
        i_m0_wreq = 0; i_m1_wreq = 0;
        chk("wr_done_clr", {o_m1_wdone, o_m0_wdone}, 0);
        chk("wr_err_clr", o_werr, 0);
    endtask

    task automatic do_rd(input bit m, input logic [9:0] idx, input logic [31:0] d,
                         input int dly, input int mode);
        if (m) begin i_m1_rreq = 1; i_m1_rreg_idx = idx; end
        else   begin i_m0_rreq = 1; i_m0_rreg_idx = idx; end
        tick;
        chk("rd_en", o_renable, 1);
        chk("rd_idx", o_rreg_idx, idx);
        for (int c = 0; c < dly; c++) begin
            chk("rd_early_done", {o_m1_rdone, o_m0_rdone}, 0);
            tick;
        end
        i_raccept = (mode != 1);
        i_rerror  = (mode != 0);
        i_rdata   = d;
        tick;
        i_raccept = 0; i_rerror = 0; i_rdata = 32'h0;
        chk("rd_done_m0", o_m0_rdone, !m);
        chk("rd_done_m1", o_m1_rdone, m);
        chk("rd_err", o_rerr, (mode != 0));
        chk("rd_data", o_rdata, d);
        tick;
        i_m0_rreq = 0; i_m1_rreq = 0;
        chk("rd_done_clr", {o_m1_rdone, o_m0_rdone}, 0);
    endtask

    // Both masters request together; each drops its req the cycle after its done.
    task automatic arb_round;
        bit d0 = 0, d1 = 0, p0 = 0, p1 = 0, busy = 0;
        i_m0_wreq = 1; i_m0_wreg_idx = 10'h100; i_m0_wdata = 32'h0000_0100;
        i_m1_wreq = 1; i_m1_wreg_idx = 10'h200; i_m1_wdata = 32'h0000_0200;
        for (int c = 0; c < 30 && !(d0 && d1); c++) begin
            tick;
            if (p0) begin i_m0_wreq = 0; p0 = 0; end
            if (p1) begin i_m1_wreq = 0; p1 = 0; end
            i_waccept = 0;
            if (o_wenable) begin
                chk("arb_no_overlap", busy, 0);
                busy = 1;
                order.push_back(o_wreg_idx);
                i_waccept = 1;
            end
            if (o_m0_wdone) begin d0 = 1; p0 = 1; busy = 0; end
            if (o_m1_wdone) begin d1 = 1; p1 = 1; busy = 0; end
        end
        tick;
        i_m0_wreq = 0; i_m1_wreq = 0; i_waccept = 0;
        chk("arb_both_done", {30'd0, d1, d0}, 32'h3);
    endtask

    initial begin
        int lat;
        rst = 1;
        i_m0_wreq = 0; i_m0_rreq = 0; i_m1_wreq = 0; i_m1_rreq = 0;
        i_m0_wreg_idx = 0; i_m0_rreg_idx = 0; i_m1_wreg_idx = 0; i_m1_rreg_idx = 0;
        i_m0_wdata = 0; i_m1_wdata = 0;
        i_waccept = 0; i_werror = 0; i_raccept = 0; i_rerror = 0; i_rdata = 0;
        tick; tick;
        chk_quiet("rst");
        chk("rst_widx", o_wreg_idx, 0);
        chk("rst_wdata", o_wdata, 0);
        chk("rst_ridx", o_rreg_idx, 0);
        chk("rst_rdata", o_rdata, 0);
        rst = 0;
        tick;

        // basic write, accept two cycles after enable; then error / both-set responses
        do_wr(0, 10'h004, 32'h0000_0001, 2, 0);
        do_wr(1, 10'h3c1, 32'hcafe_f00d, 0, 1);
        do_wr(0, 10'h0aa, 32'h1234_5678, 1, 2);
        chk("wr_idx_hold", o_wreg_idx, 10'h0aa);

        // round-robin from reset
        rst = 1; tick; rst = 0; tick;
        arb_round;
        arb_round;
        chk("arb_count", order.size(), 4);
        if (order.size() == 4) begin
            chk("arb_g0", order[0], 10'h100);
            chk("arb_g1", order[1], 10'h200);
            chk("arb_g2", order[2], 10'h100);
            chk("arb_g3", order[3], 10'h200);
        end

        // reads: accept, then error response
        do_rd(1, 10'h010, 32'hbeef_deaf, 0, 0);
        do_rd(1, 10'h010, 32'h0bad_0bad, 1, 1);

        // timeout: done on the 11th edge after req (12th cycle counting the req cycle)
        i_m0_rreq = 1; i_m0_rreg_idx = 10'h020;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (o_m0_rdone) begin lat = c; break; end
        end
        chk("to_latency", lat, 11);
        chk("to_err", o_rerr, 1);
        tick;
        i_m0_rreq = 0;
        chk("to_done_clr", o_m0_rdone, 0);
        i_raccept = 1; i_rdata = 32'hdead_0000;
        tick;
        chk("late_acc_done_a", {o_m1_rdone, o_m0_rdone}, 0);
        tick;
        chk("late_acc_done_b", {o_m1_rdone, o_m0_rdone}, 0);
        i_raccept = 0; i_rdata = 0;
        chk("late_acc_rdata", o_rdata, 32'h0bad_0bad);

        // concurrent write (error) and read (accept)
        i_m0_wreq = 1; i_m0_wreg_idx = 10'h3ff; i_m0_wdata = 32'hffff_ffff;
        i_m1_rreq = 1; i_m1_rreg_idx = 10'h001;
        tick;
        chk("cc_wen", o_wenable, 1);
        chk("cc_ren", o_renable, 1);
        chk("cc_ridx", o_rreg_idx, 10'h001);
        i_werror = 1; i_raccept = 1; i_rdata = 32'h1234_abcd;
        tick;
        i_werror = 0; i_raccept = 0; i_rdata = 0;
        chk("cc_wdone", o_m0_wdone, 1);
        chk("cc_werr", o_werr, 1);
        chk("cc_rdone", o_m1_rdone, 1);
        chk("cc_rerr", o_rerr, 0);
        chk("cc_rdata", o_rdata, 32'h1234_abcd);
        tick;
        i_m0_wreq = 0; i_m1_rreq = 0;
        chk_quiet("cc_after");

        // reset during WAIT
        i_m0_wreq = 1; i_m0_wreg_idx = 10'h055; i_m0_wdata = 32'ha5a5_a5a5;
        tick; tick; tick;
        #2 rst = 1;
        #1;
        chk_quiet("mid_rst");
        chk("mid_rst_widx", o_wreg_idx, 0);
        chk("mid_rst_wdata", o_wdata, 0);
        chk("mid_rst_rdata", o_rdata, 0);
        i_m0_wreq = 0;
        tick;
        rst = 0;
        i_waccept = 1;
        tick;
        chk("post_rst_done", {o_m1_wdone, o_m0_wdone}, 0);
        i_waccept = 0;
        tick;
        chk("post_rst_done2", {o_m1_wdone, o_m0_wdone}, 0);
        do_wr(1, 10'h2aa, 32'h5555_aaaa, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
